// File: rtl/seq_div34_pkg.sv
// Shared constants and state encoding for the 34-bit sequential restoring divider.
package seq_div34_pkg;

    localparam int DIV_N  = 34;
    localparam int DIV_CW = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [DIV_N-1:0] DZ_QUOT = {DIV_N{1'b1}};

endpackage

// File: rtl/seq_div34_div_step.sv
// One radix-2 restoring step: shift in the next dividend bit, trial-subtract, keep or restore.
module seq_div34_div_step
    import seq_div34_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic [N:0]   i_r,
    input  logic         i_q_msb,
    input  logic [N-1:0] i_divisor,
    output logic [N:0]   o_r,
    output logic         o_q_bit
);

    logic [N+1:0] w_s;
    logic [N+1:0] w_diff;

    // Widened by one bit so the borrow out of the trial subtraction doubles as the compare.
    assign w_s     = {i_r, i_q_msb};
    assign w_diff  = w_s - {2'b00, i_divisor};
    assign o_q_bit = ~w_diff[N+1];
    assign o_r     = o_q_bit ? w_diff[N:0] : w_s[N:0];

endmodule

// File: rtl/seq_div34.sv
// Sequential unsigned restoring divider, one quotient bit per clock, valid/ready on both sides.
//   state | meaning
//   IDLE  | in_ready=1, waiting for operands
//   CALC  | N shift/subtract iterations, counter counts down to 0
//   DONE  | result presented and held until out_ready
module seq_div34
    import seq_div34_pkg::*;
#(
    parameter int N  = DIV_N,
    parameter int CW = DIV_CW
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [N-1:0]  r_q;
    logic [N:0]    r_r;
    logic [N-1:0]  r_dsr;
    logic          r_dz;
    logic [CW-1:0] r_cnt;
    logic [N:0]    w_r_nxt;
    logic          w_q_bit;

    seq_div34_div_step #(.N(N)) u_step (
        .i_r       (r_r),
        .i_q_msb   (r_q[N-1]),
        .i_divisor (r_dsr),
        .o_r       (w_r_nxt),
        .o_q_bit   (w_q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_q     <= '0;
            r_r     <= '0;
            r_dsr   <= '0;
            r_dz    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_dsr <= divisor;
                        if (divisor == '0) begin
                            r_q   <= DZ_QUOT;
                            r_r   <= {1'b0, dividend};
                            r_dz  <= 1'b1;
                            r_cnt <= '0;
                        end else begin
                            r_q   <= dividend;
                            r_r   <= '0;
                            r_dz  <= 1'b0;
                            r_cnt <= CW'(N - 1);
                        end
                    end
                end
                ST_CALC: begin
                    r_q <= {r_q[N-2:0], w_q_bit};
                    r_r <= w_r_nxt;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = (divisor == '0) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Result ports stay at zero outside DONE so partial iterations are never visible.
    always_comb begin
        in_ready    = (r_state == ST_IDLE);
        out_valid   = (r_state == ST_DONE);
        quotient    = '0;
        remainder   = '0;
        div_by_zero = 1'b0;
        if (r_state == ST_DONE) begin
            quotient    = r_q;
            remainder   = r_r[N-1:0];
            div_by_zero = r_dz;
        end
    end

endmodule

// File: tb/tb_seq_div34.sv
// Self-checking bench for seq_div34: directed table, reset corner case, randomized ops vs. arithmetic model.
module tb_seq_div34;

    localparam int NB = 34;
    localparam logic [NB-1:0] ALL1 = {NB{1'b1}};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [NB-1:0] dividend = '0;
    logic [NB-1:0] divisor = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [NB-1:0] quotient;
    logic [NB-1:0] remainder;
    logic          div_by_zero;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [NB-1:0] dvd;
        logic [NB-1:0] dsr;
        int            hold;
        logic [NB-1:0] exp_q;
        logic [NB-1:0] exp_r;
        logic          exp_dz;
    } vec_t;

    vec_t vecs[9];

    seq_div34 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [NB-1:0] a, input logic [NB-1:0] b, input int hold,
                          input logic [NB-1:0] eq, input logic [NB-1:0] er, input logic edz);
        int            w;
        int            lat;
        bit            busy_bad;
        bit            hold_bad;
        logic [63:0]   rnd;
        logic [NB-1:0] q0;
        logic [NB-1:0] r0;
        w = 0;
        while (!in_ready && w < 200) begin
            tick();
            w++;
        end
        chk("in_ready_idle", in_ready, 1);
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        tick();
        lat = 0;
        busy_bad = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_bad = 1;
            // Garbage on the input side while busy must be ignored.
            rnd      = {$urandom, $urandom};
            dividend = rnd[NB-1:0];
            divisor  = rnd[NB+9:10];
            in_valid = 1'($urandom_range(0, 1));
            tick();
            lat++;
        end
        in_valid = 1'b0;
        chk("latency", lat, (b == '0) ? 0 : NB);
        chk("in_ready_busy", busy_bad, 0);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_by_zero", div_by_zero, edz);
        if (b != '0) begin
            chk("reconstruct", 72'(quotient) * 72'(b) + 72'(remainder), 72'(a));
            chk("rem_lt_div", remainder < b, 1);
        end
        q0 = quotient;
        r0 = remainder;
        hold_bad = 0;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (!out_valid || quotient !== q0 || remainder !== r0 || div_by_zero !== edz) hold_bad = 1;
        end
        if (hold > 0) chk("hold_stable", hold_bad, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_drop", out_valid, 0);
        chk("in_ready_back", in_ready, 1);
    endtask

    initial begin
        logic [63:0]   rnd;
        logic [NB-1:0] a;
        logic [NB-1:0] b;
        logic [NB-1:0] mq;
        logic [NB-1:0] mr;
        logic          mdz;
        int            mode;

        vecs[0] = '{dvd: 100,           dsr: 7,               hold: 0, exp_q: 14,           exp_r: 2,           exp_dz: 0};
        vecs[1] = '{dvd: ALL1,          dsr: 1,               hold: 0, exp_q: ALL1,         exp_r: 0,           exp_dz: 0};
        vecs[2] = '{dvd: ALL1,          dsr: ALL1,            hold: 0, exp_q: 1,            exp_r: 0,           exp_dz: 0};
        vecs[3] = '{dvd: 12345,         dsr: 0,               hold: 0, exp_q: ALL1,         exp_r: 12345,       exp_dz: 1};
        vecs[4] = '{dvd: 5,             dsr: 9,               hold: 5, exp_q: 0,            exp_r: 5,           exp_dz: 0};
        vecs[5] = '{dvd: 0,             dsr: 5,               hold: 0, exp_q: 0,            exp_r: 0,           exp_dz: 0};
        vecs[6] = '{dvd: 1000,          dsr: 3,               hold: 0, exp_q: 333,          exp_r: 1,           exp_dz: 0};
        vecs[7] = '{dvd: 34'h200000000, dsr: 34'h200000001,   hold: 0, exp_q: 0,            exp_r: 34'h200000000, exp_dz: 0};
        vecs[8] = '{dvd: ALL1,          dsr: 34'h000010000,   hold: 1, exp_q: 34'h3FFFF,    exp_r: 34'hFFFF,    exp_dz: 0};

        #3;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dz", div_by_zero, 0);
        tick();
        #3 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].dvd, vecs[i].dsr, vecs[i].hold, vecs[i].exp_q, vecs[i].exp_r, vecs[i].exp_dz);
        end

        // Asynchronous reset in the middle of CALC abandons the operation.
        dividend = 1000;
        divisor  = 3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        chk("calc_busy", in_ready, 0);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_quotient", quotient, 0);
        chk("arst_remainder", remainder, 0);
        chk("arst_dz", div_by_zero, 0);
        tick();
        tick();
        #3 rst_n = 1'b1;
        repeat (3) begin
            tick();
            chk("no_stale_valid", out_valid, 0);
        end
        run_op(1000, 3, 0, 333, 1, 0);

        for (int i = 0; i < 1500; i++) begin
            rnd  = {$urandom, $urandom};
            a    = rnd[NB-1:0];
            mode = $urandom_range(0, 7);
            rnd  = {$urandom, $urandom};
            case (mode)
                0: b = '0;
                1: b = NB'($urandom_range(1, 15));
                2: b = ALL1 - NB'($urandom_range(0, 3));
                3: b = rnd[NB-1:0] >> $urandom_range(1, 33);
                default: b = rnd[NB-1:0];
            endcase
            if (mode == 4) a = a >> $urandom_range(0, 33);
            if (b == '0) begin
                mq  = ALL1;
                mr  = a;
                mdz = 1'b1;
            end else begin
                mq  = a / b;
                mr  = a % b;
                mdz = 1'b0;
            end
            run_op(a, b, $urandom_range(0, 2), mq, mr, mdz);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
